// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest legal value of a single BCD digit.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Default geometry: four digits, and ceil(log2(10^4)) = 14 result bits.
    localparam int NDIG_DEF = 4;
    localparam int BW_DEF   = 14;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
interface bcd_to_bin_seq_if
    import bcd_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int BW   = BW_DEF
);

    logic                start;
    logic [4*NDIG-1:0]   bcd_in;
    logic [BW-1:0]       bin_out;
    logic                valid;
    logic                busy;
    logic                err;

    // Requester side: issues operands, observes results.
    modport master (
        output start,
        output bcd_in,
        input  bin_out,
        input  valid,
        input  busy,
        input  err
    );

    // Converter side: accepts operands, produces results.
    modport slave (
        input  start,
        input  bcd_in,
        output bin_out,
        output valid,
        output busy,
        output err
    );

endinterface

// File: rtl/bcd_mac10.sv
// One Horner step of BCD conversion: acc*10 + digit, plus a flag for digits above 9.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BW = BW_DEF
) (
    input  logic [BW-1:0] acc,
    input  logic [3:0]    digit,
    output logic [BW-1:0] acc_next,
    output logic          digit_bad
);

    // acc*10 built from two shifts so no multiplier is inferred; wraps at BW bits,
    // which only matters once an illegal digit has already poisoned the result.
    assign acc_next  = (acc << 3) + (acc << 1) + BW'(digit);

    // Digits 10..15 are not BCD; they still feed the sum but mark the result bad.
    assign digit_bad = (digit > DIGIT_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int BW   = BW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_to_bin_seq_if.slave     bus
);

    localparam int              CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0]   LAST = CW'(NDIG - 1);

    state_t              state;
    logic [4*NDIG-1:0]   operand;
    logic [BW-1:0]       acc;
    logic [CW-1:0]       cnt;
    logic                err_flag;

    logic [BW-1:0]       bin_q;
    logic                err_q;
    logic                valid_q;
    logic                busy_q;

    logic [3:0]          digit;
    logic [BW-1:0]       acc_next;
    logic                digit_bad;
    logic                err_next;

    // The operand is shifted left each cycle, so the digit in play is always the top nibble.
    assign digit    = operand[4*NDIG-1 -: 4];
    assign err_next = err_flag | digit_bad;

    bcd_mac10 #(.BW(BW)) u_mac10 (
        .acc       (acc),
        .digit     (digit),
        .acc_next  (acc_next),
        .digit_bad (digit_bad)
    );

    // Control FSM and datapath registers; every output is a flop so nothing is combinational to the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            operand  <= '0;
            acc      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every read below sees the pre-edge value
            // (e.g. the final CONV cycle uses the old err_flag and the old acc via acc_next).
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        operand  <= bus.bcd_in;
                        acc      <= '0;
                        cnt      <= '0;
                        err_flag <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= ST_CONV;
                    end
                end

                ST_CONV: begin
                    acc      <= acc_next;
                    operand  <= operand << 4;
                    err_flag <= err_next;
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Result is taken straight from the adder so the last digit is included.
                        bin_q   <= err_next ? '0 : acc_next;
                        err_q   <= err_next;
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: timing, results, error path, start masking, mid-run reset.
module tb_bcd_to_bin_seq;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_bin_seq_if #(.NDIG(4), .BW(14)) bus ();

    bcd_to_bin_seq #(.NDIG(4), .BW(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. Issues one start pulse, then watches the 8 cycles after the
    // capture edge N. Cycle i is the one following edge N+i: busy must be high for i=0..4,
    // valid only at i=4, and the result must then hold. With disturb set, start is re-raised
    // and bcd_in changed during CONV, and start is kept high through the DONE cycle.
    task automatic run(input string tag, input logic [15:0] bcd, input logic [13:0] exp_bin,
                       input logic exp_err, input bit disturb);
        int n_valid;
        n_valid     = 0;
        bus.start   = 1'b1;
        bus.bcd_in  = bcd;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, i), 32'(bus.busy), 32'(i <= 4));
            check($sformatf("%s valid c%0d", tag, i), 32'(bus.valid), 32'(i == 4));
            if (bus.valid) n_valid++;
            if (i >= 4) begin
                check($sformatf("%s bin c%0d", tag, i), 32'(bus.bin_out), 32'(exp_bin));
                check($sformatf("%s err c%0d", tag, i), 32'(bus.err), 32'(exp_err));
            end
            if (!disturb) begin
                bus.start = 1'b0;
            end else if (i == 1) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h5555;
            end else if (i == 5) begin
                bus.start = 1'b0;
            end
        end
        check({tag, " valid count"}, 32'(n_valid), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;

        #2;
        check("reset bin",   32'(bus.bin_out), 32'd0);
        check("reset valid", 32'(bus.valid),   32'd0);
        check("reset busy",  32'(bus.busy),    32'd0);
        check("reset err",   32'(bus.err),     32'd0);

        // Release reset and request in the same cycle: the first high edge must accept it.
        @(negedge clk);
        rst_n = 1'b1;
        run("zero", 16'h0000, 14'd0,    1'b0, 1'b0);

        @(negedge clk);
        run("1234", 16'h1234, 14'd1234, 1'b0, 1'b0);
        @(negedge clk);
        run("9999", 16'h9999, 14'd9999, 1'b0, 1'b0);
        @(negedge clk);
        run("12A4", 16'h12A4, 14'd0,    1'b1, 1'b0);
        @(negedge clk);
        run("0042", 16'h0042, 14'd42,   1'b0, 1'b0);
        @(negedge clk);
        run("0007", 16'h0007, 14'd7,    1'b0, 1'b1);

        // Reset two cycles into a conversion: outputs clear immediately, no result follows.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h8888;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre-rst busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst bin",   32'(bus.bin_out), 32'd0);
        check("rst valid", 32'(bus.valid),   32'd0);
        check("rst busy",  32'(bus.busy),    32'd0);
        check("rst err",   32'(bus.err),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int n_valid;
            n_valid = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.valid) n_valid++;
            end
            check("post-rst no valid", 32'(n_valid), 32'd0);
            check("post-rst idle",     32'(bus.busy), 32'd0);
        end
        run("0100", 16'h0100, 14'd100, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning number of packed BCD digits converted.
REQ-002 SHALL have parameter BW, default 14, meaning binary result width (ceil(log2(10^NDIG))).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to convert; sampled only in IDLE.
REQ-006 SHALL have port bcd_in  input  4*NDIG  packed BCD operand; most significant digit in the top nibble.
REQ-007 SHALL have port bin_out  output  BW  binary result; held until the next result.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking a new bin_out/err.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress (CONV or DONE).
REQ-010 SHALL have port err  output  1  high with valid when any digit was >9; held with bin_out.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, DONE.
REQ-012 SHALL, in IDLE with start=1 at edge N, capture bcd_in into an operand register, clear the accumulator, clear the digit counter and the error flag, and go to CONV.
REQ-013 SHALL, in CONV, process one digit per cycle from the most significant digit down: acc <= acc*10 + digit, with acc*10 formed as (acc<<3)+(acc<<1).
REQ-014 SHALL set the sticky error flag when any processed digit is in 10..15; such a digit still enters the accumulator.
REQ-015 SHALL leave CONV after NDIG digit cycles (edges N+1..N+NDIG) and enter DONE at edge N+NDIG.
REQ-016 SHALL, on entry to DONE, load bin_out with acc (or with 0 when the error flag is set) and load err with the error flag.
REQ-017 SHALL drive valid=1 only during the DONE cycle; DONE SHALL return to IDLE on the next edge. With NDIG=4, valid is high in the cycle after edge N+4.
REQ-018 SHALL ignore start in CONV and DONE, with no queuing; the earliest accepted restart is in the first IDLE cycle after DONE.
REQ-019 SHALL keep bcd_in changes after the capture edge from affecting the running conversion.
REQ-020 SHALL keep acc arithmetic BW bits wide; with valid digits the maximum result (10^NDIG - 1) fits without overflow. Truncation to BW bits is acceptable only in error cases.
REQ-021 SHALL drive busy=1 exactly while the state is not IDLE.

Reset
REQ-022 SHALL, on rst_n=0 and at any time including mid-conversion, immediately force state=IDLE, bin_out=0, err=0, valid=0, busy=0, and clear acc, the counter and the operand register.
REQ-023 SHALL, after rst_n deasserts, accept start on the first rising edge at which rst_n is high.

Structure
REQ-024 SHALL place the state encoding (IDLE, CONV, DONE), the digit-maximum constant (9) and the default NDIG/BW values in the shared package bcd_pkg.
REQ-025 SHALL isolate the multiply-by-10-and-add datapath in one sub-module bcd_mac10 (inputs acc and digit; outputs next acc and a digit-invalid flag), instantiated once.
REQ-026 SHALL use no combinational path from any input to any output; all outputs are registered.

Verification
REQ-027 SHALL cover: bcd_in=16'h0000 with a start pulse -> valid one cycle after edge N+4, bin_out=0, err=0.
REQ-028 SHALL cover: bcd_in=16'h1234 -> bin_out=14'd1234 (0x4D2), err=0; busy high for exactly 5 cycles.
REQ-029 SHALL cover: bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F), err=0.
REQ-030 SHALL cover: bcd_in=16'h12A4 -> valid=1, err=1, bin_out=0; a following conversion of 16'h0042 -> bin_out=42, err=0.
REQ-031 SHALL cover: start re-asserted and bcd_in changed to 16'h5555 during CONV of 16'h0007 -> single valid, bin_out=7; start in DONE produces no second conversion.
REQ-032 SHALL cover: rst_n pulsed low two cycles into a conversion -> all outputs 0 immediately, no valid; a new start of 16'h0100 afterwards -> bin_out=100.
